// File: rtl/tiny_dnn_pkg.sv
// rtl/tiny_dnn_pkg.sv - shared lane count and packed source-beat type
package tiny_dnn_pkg;

  localparam int SRC_LANES = 4;
  localparam int SRC_DW    = 32;

  typedef struct packed {
    logic                             last;
    logic [SRC_LANES-1:0][SRC_DW-1:0] d;
  } src_beat_t;

endpackage

// File: rtl/src_pack_fifo.sv
// rtl/src_pack_fifo.sv - beat FIFO (module src_fifo) with a registered head
// The head register trails the storage array by one edge, so a push into an empty FIFO shows at the head one cycle later.
module src_fifo
  import tiny_dnn_pkg::*;
#(
  parameter type BEAT_T = src_beat_t,
  parameter int  DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  BEAT_T         push_data,
  input  logic          pop,
  output logic          head_valid,
  output BEAT_T         head_data,
  output logic [CW-1:0] count
);

  BEAT_T         r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_head_valid;
  BEAT_T         r_head_data;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_remain;

  assign w_rd_ptr_nxt = r_rd_ptr + AW'(pop);
  assign w_remain     = r_count - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Entries already stored before this edge, minus the one popped, decide the next head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_head_valid <= 1'b0;
      r_head_data  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_count      <= r_count + CW'(push) - CW'(pop);
      r_head_valid <= (w_remain != '0);
      if (w_remain != '0) begin
        r_head_data <= r_mem[w_rd_ptr_nxt];
      end
    end
  end

  assign head_valid = r_head_valid;
  assign head_data  = r_head_data;
  assign count      = r_count;

endmodule

// File: rtl/src_pack.sv
// rtl/src_pack.sv - packs four input words into one 4-lane beat behind a beat FIFO
// Define SRC_PACK_CNT_EN to add the 16-bit beat_cnt delivered-beat counter.
module src_pack
  import tiny_dnn_pkg::*;
#(
  parameter int DW    = SRC_DW,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          src_valid,
  output logic [DW-1:0] src_data0,
  output logic [DW-1:0] src_data1,
  output logic [DW-1:0] src_data2,
  output logic [DW-1:0] src_data3,
  output logic          src_last,
  input  logic          src_ready
`ifdef SRC_PACK_CNT_EN
  ,
  output logic [15:0]   beat_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic                         last;
    logic [SRC_LANES-1:0][DW-1:0] d;
  } beat_t;

  logic                         r_up;
  logic [1:0]                   r_lane;
  logic [SRC_LANES-2:0][DW-1:0] r_asm;
  logic                         w_acc;
  logic                         w_done;
  logic                         w_pop;
  logic                         w_head_valid;
  logic [CW-1:0]                w_count;
  beat_t                        w_beat;
  beat_t                        w_head;

  // Space is reserved for a whole beat before its first word is taken, so assembly never stalls.
  assign in_ready = r_up && (w_count < CW'(DEPTH));
  assign w_acc    = in_valid && in_ready;
  assign w_done   = w_acc && (in_last || (r_lane == 2'(SRC_LANES - 1)));
  assign w_pop    = w_head_valid && src_ready;

  always_comb begin
    w_beat      = '0;
    w_beat.last = in_last;
    for (int k = 0; k < SRC_LANES - 1; k++) begin
      if (2'(k) < r_lane) begin
        w_beat.d[k] = r_asm[k];
      end
    end
    for (int k = 0; k < SRC_LANES; k++) begin
      if (2'(k) == r_lane) begin
        w_beat.d[k] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up   <= 1'b0;
      r_lane <= '0;
      r_asm  <= '0;
    end else begin
      r_up <= 1'b1;
      if (w_acc) begin
        if (w_done) begin
          r_lane <= '0;
        end else begin
          r_lane <= r_lane + 2'd1;
          for (int k = 0; k < SRC_LANES - 1; k++) begin
            if (r_lane == 2'(k)) begin
              r_asm[k] <= in_data;
            end
          end
        end
      end
    end
  end

  src_fifo #(
    .BEAT_T (beat_t),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (w_done),
    .push_data  (w_beat),
    .pop        (w_pop),
    .head_valid (w_head_valid),
    .head_data  (w_head),
    .count      (w_count)
  );

  assign src_valid = w_head_valid;
  assign src_last  = w_head.last;
  assign src_data0 = w_head.d[0];
  assign src_data1 = w_head.d[1];
  assign src_data2 = w_head.d[2];
  assign src_data3 = w_head.d[3];

`ifdef SRC_PACK_CNT_EN
  logic [15:0] r_beat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
    end else if (w_pop) begin
      r_beat_cnt <= r_beat_cnt + 16'd1;
    end
  end

  assign beat_cnt = r_beat_cnt;
`endif

endmodule

// File: tb/tb_src_pack.sv
// tb/tb_src_pack.sv - table vectors, corner sequences and a random scoreboard for src_pack
module tb_src_pack;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef logic [128:0] bt_t;
  typedef struct packed {
    logic [3:0]        nw;
    logic [31:0]       base;
    logic [7:0]        lastm;
    logic [1:0]        nb;
    logic [2:0][128:0] e;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          src_valid;
  logic [DW-1:0] src_data0, src_data1, src_data2, src_data3;
  logic          src_last;
  logic          src_ready = 1'b0;
`ifdef SRC_PACK_CNT_EN
  logic [15:0]   beat_cnt;
`endif

  bt_t         exp_q[$];
  bt_t         got_q[$];
  logic [31:0] cur_q[$];
  int          passed = 0;
  int          total = 0;
  int          cyc = 0;
  int          npop = 0;
  logic        rr_en = 1'b0;
  vec_t        tbl[5];

  src_pack #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .src_valid (src_valid),
    .src_data0 (src_data0),
    .src_data1 (src_data1),
    .src_data2 (src_data2),
    .src_data3 (src_data3),
    .src_last  (src_last),
    .src_ready (src_ready)
`ifdef SRC_PACK_CNT_EN
    ,
    .beat_cnt  (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic bt_t bt(input logic l, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] d);
    return {l, d, c, b, a};
  endfunction

  task automatic chk(input string name, input bt_t act, input bt_t exp_v);
    total++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp_v);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp_v);
    chk(name, 129'(act), 129'(exp_v));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int   t;
    logic ok;
    t = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!ok && t < 300) begin
      @(negedge clk);
      ok = in_ready;
      if (!ok) begin
        @(posedge clk);
        #1;
      end
      t++;
    end
    if (!ok) chk1("send_timeout", ok, 1'b1);
    else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Reference: words gather into a packet-local list; four words or a last word close a beat.
  always @(negedge clk) begin
    bt_t b;
    int  sz0;
    if (rst_n) begin
      sz0 = exp_q.size();
      chk1("in_ready", in_ready, (cyc >= 1) && (sz0 < DEPTH));
      if (src_valid && src_ready) begin
        b = {src_last, src_data3, src_data2, src_data1, src_data0};
        got_q.push_back(b);
        npop++;
        chk1("beat_expected", sz0 != 0, 1'b1);
        if (sz0 != 0) chk("beat_order", b, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        cur_q.push_back(in_data);
        if (cur_q.size() == 4 || in_last) begin
          b = '0;
          foreach (cur_q[k]) b[k*32 +: 32] = cur_q[k];
          b[128] = in_last;
          chk1("push_while_full", sz0 < DEPTH, 1'b1);
          exp_q.push_back(b);
          cur_q.delete();
        end
      end
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          len;
    int          words;
    int          t;
    logic [31:0] w;

    tbl[0] = '{nw: 4'd8, base: 32'd1,  lastm: 8'h80, nb: 2'd2,
               e: {bt(0, 0, 0, 0, 0), bt(1, 5, 6, 7, 8), bt(0, 1, 2, 3, 4)}};
    tbl[1] = '{nw: 4'd6, base: 32'd1,  lastm: 8'h20, nb: 2'd2,
               e: {bt(0, 0, 0, 0, 0), bt(1, 5, 6, 0, 0), bt(0, 1, 2, 3, 4)}};
    tbl[2] = '{nw: 4'd1, base: 32'd9,  lastm: 8'h01, nb: 2'd1,
               e: {bt(0, 0, 0, 0, 0), bt(0, 0, 0, 0, 0), bt(1, 9, 0, 0, 0)}};
    tbl[3] = '{nw: 4'd4, base: 32'd1,  lastm: 8'h08, nb: 2'd1,
               e: {bt(0, 0, 0, 0, 0), bt(0, 0, 0, 0, 0), bt(1, 1, 2, 3, 4)}};
    tbl[4] = '{nw: 4'd5, base: 32'd10, lastm: 8'h12, nb: 2'd2,
               e: {bt(0, 0, 0, 0, 0), bt(1, 12, 13, 14, 0), bt(1, 10, 11, 0, 0)}};

    tick(3);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_src_valid", src_valid, 1'b0);
    chk("rst_head", {src_last, src_data3, src_data2, src_data1, src_data0}, '0);
`ifdef SRC_PACK_CNT_EN
    chk("rst_beat_cnt", 129'(beat_cnt), '0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk1("up_delay0", in_ready, 1'b0);
    tick(1);
    @(negedge clk);
    chk1("up_delay1", in_ready, 1'b1);
    tick(1);

    // Latency through an empty FIFO
    send(32'd9, 1'b1);
    @(negedge clk);
    chk1("lat_edge_n", src_valid, 1'b0);
    @(negedge clk);
    chk1("lat_edge_n1", src_valid, 1'b1);
    chk("lat_beat", {src_last, src_data3, src_data2, src_data1, src_data0}, bt(1, 9, 0, 0, 0));
    tick(1);
    src_ready = 1'b1;
    tick(4);

    for (int i = 0; i < 5; i++) begin
      got_q.delete();
      src_ready = 1'b1;
      for (int j = 0; j < int'(tbl[i].nw); j++) send(tbl[i].base + 32'(j), tbl[i].lastm[j]);
      tick(12);
      chk($sformatf("tbl%0d_nbeats", i), 129'(got_q.size()), 129'(tbl[i].nb));
      for (int b = 0; b < int'(tbl[i].nb); b++)
        if (b < got_q.size()) chk($sformatf("tbl%0d_beat%0d", i, b), got_q[b], tbl[i].e[b]);
    end

    // Core stall: FIFO fills after 16 words, head holds, then drains in order
    got_q.delete();
    src_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send(32'(i), 1'b0);
    @(negedge clk);
    chk1("stall_in_ready", in_ready, 1'b0);
    chk1("stall_src_valid", src_valid, 1'b1);
    chk("stall_head", {src_last, src_data3, src_data2, src_data1, src_data0}, bt(0, 1, 2, 3, 4));
    tick(4);
    @(negedge clk);
    chk("stall_hold", {src_last, src_data3, src_data2, src_data1, src_data0}, bt(0, 1, 2, 3, 4));
    tick(1);
    fork
      for (int i = 17; i <= 20; i++) send(32'(i), i == 20);
      begin
        tick(4);
        src_ready = 1'b1;
      end
    join
    tick(20);
    chk("stall_nbeats", 129'(got_q.size()), 129'(5));
    if (got_q.size() == 5) begin
      chk("stall_first", got_q[0], bt(0, 1, 2, 3, 4));
      chk("stall_final", got_q[4], bt(1, 17, 18, 19, 20));
    end

    // Reset mid-packet with one beat queued
    src_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(32'(i), 1'b0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!src_valid && t < 20);
    chk1("mid_rst_queued", src_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_src_valid", src_valid, 1'b0);
    chk1("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_head", {src_last, src_data3, src_data2, src_data1, src_data0}, '0);
    exp_q.delete();
    cur_q.delete();
    cyc = 0;
    npop = 0;
    tick(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rel_in_ready0", in_ready, 1'b0);
    tick(1);
    @(negedge clk);
    chk1("rel_in_ready1", in_ready, 1'b1);
    tick(1);
    got_q.delete();
    src_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(32'(i), i == 4);
    tick(10);
    chk("rel_nbeats", 129'(got_q.size()), 129'(1));
    if (got_q.size() == 1) chk("rel_beat", got_q[0], bt(1, 1, 2, 3, 4));

`ifdef SRC_PACK_CNT_EN
    rst_n = 1'b0;
    #1;
    chk("cnt_cleared", 129'(beat_cnt), '0);
    exp_q.delete();
    cur_q.delete();
    cyc = 0;
    npop = 0;
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) send(32'(100 + i), 1'b1);
    tick(12);
    chk("cnt_five", 129'(beat_cnt), 129'(5));
`endif

    // Random traffic against the scoreboard
    rr_en = 1'b1;
    fork
      while (rr_en) begin
        @(posedge clk);
        #1;
        src_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    words = 0;
    while (words < 1000) begin
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
        w = $urandom;
        send(w, i == len - 1);
        words++;
      end
    end
    rr_en = 1'b0;
    tick(2);
    src_ready = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || src_valid) && t < 200) begin
      tick(1);
      t++;
    end
    chk("rand_drained", 129'(exp_q.size()), '0);
    chk("rand_no_partial", 129'(cur_q.size()), '0);
`ifdef SRC_PACK_CNT_EN
    chk("cnt_end", 129'(beat_cnt), 129'(16'(npop)));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/src_pack.md
# src_pack

Upstream stage of the accelerator core's source-stream input. Accepts a stream of single words from the host/DMA side and packs four consecutive words into one 4-lane beat, driving the core's `src_valid`/`src_data0..3`/`src_last`/`src_ready` handshake. A small beat FIFO decouples host bursts from core stalls. When a packet ends mid-beat, the unfilled lanes are zero-padded.

## Interface
- `DW`, 32: word width in bits; all lanes use the same width.
- `DEPTH`, 4: beat FIFO depth in beats; must be a power of two, ≥2.

Ports:
- `clk`  in  1: clock; everything is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: input word valid.
- `in_data`  in  DW: input word.
- `in_last`  in  1: final word of the packet.
- `in_ready`  out  1: the block accepts a word this cycle.
- `src_valid`  out  1: packed beat valid.
- `src_data0`..`src_data3`  out  DW each: beat lanes 0..3; lane 0 holds the earliest word.
- `src_last`  out  1: final beat of the packet.
- `src_ready`  in  1: the core accepts the beat.
- `beat_cnt`  out  16: count of beats delivered. Present only with `SRC_PACK_CNT_EN`.

## Operation
- A word transfers when `in_valid && in_ready`. A beat transfers when `src_valid && src_ready`.
- The 2-bit `lane` pointer selects the assembly-register lane that receives the accepted word.
- A beat completes when an accepted word lands in lane 3, or when an accepted word has `in_last=1` in any lane.
- On completion:
  - The beat is written to the FIFO in the same cycle.
  - Lanes above the final lane are written with 0.
  - The beat's last flag is set to `in_last`.
  - `lane` returns to 0.
- `in_ready = up && (fifo_count < DEPTH)`. `up` is a flag cleared by reset and set on the first clock after reset is released. Because of this rule, a completing word always finds space in the FIFO and the assembly register never stalls.
- FIFO head drives `src_valid`, `src_data*` and `src_last` directly from registers.
- Head outputs stay stable while `src_valid && !src_ready`.
- Simultaneous push and pop leave `fifo_count` unchanged. Push while full cannot occur by construction; the bench must flag it as an error if it does.
- Pointers wrap modulo `DEPTH`. `fifo_count` is `$clog2(DEPTH)+1` bits wide.
- `in_last` on a word landing in lane 3 produces a full beat with `src_last=1`; no extra beat follows.
- Reset asserted mid-packet:
  - The partial beat and all FIFO contents are discarded.
  - `src_valid` drops asynchronously.
  - The next accepted word goes to lane 0.

## Timing
- Reset values:
  - `in_ready=0`, `src_valid=0`, `src_last=0`, `src_data0..3=0`.
  - `lane=0`, `fifo_count=0`, `beat_cnt=0`.
- `in_ready` rises one cycle after `rst_n` deasserts.
- Latency: a completing word accepted at edge N gives `src_valid=1` after edge N+1 into an empty FIFO. Data never bypasses the FIFO.
- `in_ready` depends only on registered state. There is no combinational path from `src_ready` or `in_valid` to any output.
- Full throughput: one word per cycle in, with `src_ready` held high. Beats leave at one per four cycles, or faster for short packets.
- Once the FIFO frees a slot, `in_ready` reasserts one cycle after the pop edge.

## Configuration
- `SRC_PACK_CNT_EN` defined:
  - Adds the `beat_cnt` port.
  - `beat_cnt` increments on each beat transfer and wraps at 16 bits.
  - Reset clears it to 0.
- Undefined: the port and its counter logic are absent. All other behaviour is identical.

## Structure
- Shared package `tiny_dnn_pkg`:
  - `SRC_LANES = 4`.
  - `typedef struct packed { logic last; logic [SRC_LANES-1:0][DW-1:0] d; } src_beat_t`, parameterised via a package-level `DW` default of 32.
- One sub-module, `src_fifo`:
  - Synchronous FIFO, `DEPTH` entries of `src_beat_t`.
  - Registered head; `count`, `push` and `pop` ports; async active-low reset.
- `src_pack` itself holds the assembly register, the lane pointer, the `up` flag and the optional counter.

## Test plan
- Words 1..8 with `in_last` on 8, `src_ready=1` → beats {1,2,3,4} `last=0`, then {5,6,7,8} `last=1`; exactly 2 beats.
- Words 1..6 with last on 6 → {1,2,3,4} `last=0`, then {5,6,0,0} `last=1`. Single word 9 with last → {9,0,0,0} `last=1`.
- `src_ready=0`, `DEPTH=4`, stream 20 words → `in_ready` falls after word 16 is accepted. Release `src_ready` → all 20 words delivered in order, and head data holds stable across the stall.
- Random `in_valid`/`src_ready` toggling over 1000 words with random packet lengths → scoreboard matches lane order, zero padding and `last` positions; no push while full.
- Assert `rst_n` low after 2 words of a packet with one beat queued → `src_valid=0` immediately; after release, `in_ready=1` one cycle later. Words 1..4 with last → a single beat {1,2,3,4} `last=1`.
- With `SRC_PACK_CNT_EN`: deliver 5 beats → `beat_cnt=5`; a reset returns it to 0.
